seq_updown_fsm: RTL and testbench
=================================

Name: seq_updown_fsm

Overview:
- Registered, parametrised up/down sequence counter.
- Generalises the fixed 3-bit combinational next-state logic into a WIDTH-bit state machine.
- Holds its own state register and selects binary or Gray output encoding at run time.
- Supports modulus, enable, synchronous load and wrap/terminal flags.
- Drives the display/sequencer stage of the FSM datapath.

Parameters:
- WIDTH, 3: state width in bits; legal range 2..16.
- MODULUS, 2**WIDTH: count range is 0..MODULUS-1; legal range 2..2**WIDTH.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  advance one step on this edge.
- down  input  1  0 = count up, 1 = count down; sampled only with en.
- gray_mode  input  1  0 = code_o binary, 1 = code_o Gray.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value to load, interpreted in the current gray_mode encoding.
- code_o  output  WIDTH  registered state in the selected encoding.
- bin_o  output  WIDTH  registered state, always binary.
- wrap_o  output  1  one-cycle pulse on the edge the count wraps.
- term_o  output  1  combinational; high when the next en step would wrap (cnt==MODULUS-1 with down=0, or cnt==0 with down=1).

Behaviour:
- Internal register cnt holds the binary state.
  - bin_o = cnt.
  - code_o is registered as enc(next cnt, gray_mode).
  - gray(x) = x ^ (x>>1).
- Reset, when rst_n=0 at the edge:
  - cnt=0, code_o=0, bin_o=0, wrap_o=0.
  - Reset overrides load and en, including mid-sequence.
- Priority at each edge: reset > load > en > hold.
- Load:
  - cnt <= (gray_mode ? gray2bin(load_val) : load_val).
  - If the decoded value is >= MODULUS, cnt <= MODULUS-1.
  - wrap_o <= 0.
  - The loaded value is visible on code_o and bin_o at the next edge (1-cycle latency).
- Step up (en=1, down=0, load=0):
  - cnt <= cnt+1, or 0 if cnt==MODULUS-1; in the wrap case wrap_o <= 1.
- Step down (en=1, down=1, load=0):
  - cnt <= cnt-1, or MODULUS-1 if cnt==0; in the wrap case wrap_o <= 1.
- Hold (en=0, load=0): cnt unchanged, wrap_o <= 0.
- wrap_o is high for exactly one cycle per wrap. Back-to-back wraps with MODULUS=2 give a continuous high.
- Direction change takes effect on the first en edge where down is sampled; there is no extra latency.
- gray_mode change with en=0:
  - code_o re-encodes at the next edge.
  - cnt is unaffected.
- Gray output is a true single-bit-change cycle only when MODULUS==2**WIDTH. For other moduli code_o is gray(cnt), with no cyclic guarantee.
- Arithmetic is in WIDTH bits. No intermediate value exceeds MODULUS-1.

Optional Feature:
- Macro: SEQ_UPDOWN_SATURATE_EN.
- When defined:
  - At the limit, en holds cnt (MODULUS-1 counting up, 0 counting down) instead of wrapping.
  - wrap_o is never asserted.
  - term_o means "at limit in the current direction".
- When undefined: modulo wrap as described in Behaviour.
- Port list is identical in both builds.

Decomposition:
- Shared package seq_fsm_pkg:
  - enc_mode_t enum (ENC_BIN, ENC_GRAY).
  - Constants MAX_WIDTH=16 and DEFAULT_WIDTH=3.
  - Functions bin2gray and gray2bin, parametrised by width.
- One sub-module: seq_step_logic.
  - Combinational next-count, wrap and term calculation.
  - seq_updown_fsm instantiates it and owns all registers.

Test Plan (WIDTH=3):
- Reset/hold: rst_n=0 for 2 cycles, then en=0 for 3 cycles → code_o=0, bin_o=0, wrap_o=0 throughout.
- Binary up wrap: 8 en cycles, down=0, gray_mode=0 → bin_o 1..7,0; wrap_o high only on the edge 7→0; term_o high while bin_o=7.
- Gray down: gray_mode=1, down=1, en from 0 → code_o 100, 101, 111, 110, 010, 011, 001, 000; every transition changes exactly one bit.
- Load priority: load=1 with load_val=5, en=1, gray_mode=0 → bin_o=5 next cycle, wrap_o=0. MODULUS=6 with load_val=7 → bin_o clamps to 5.
- Reset mid-run: count to 4, assert rst_n=0 together with load=1 → bin_o=0, code_o=0 next cycle.
- Saturate build (SEQ_UPDOWN_SATURATE_EN): up from 6 for 3 en cycles → 7,7,7 with wrap_o=0; then down → 6.

Source files
------------

// File: rtl/seq_updown_fsm_pkg.sv
// Shared types, limits and Gray-code helpers for the up/down sequence counter.
// Optional build macro: SEQ_UPDOWN_SATURATE_EN (consumed by seq_step_logic).
package seq_fsm_pkg;

   localparam int MAX_WIDTH     = 16;
   localparam int DEFAULT_WIDTH = 3;

   typedef enum logic {
      ENC_BIN  = 1'b0,
      ENC_GRAY = 1'b1
   } enc_mode_t;

   // Both helpers work on zero-extended MAX_WIDTH values, so any WIDTH up to
   // MAX_WIDTH is handled by extending the argument and truncating the result.
   function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
      logic [MAX_WIDTH-1:0] b;
      b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
      for (int i = MAX_WIDTH-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/seq_updown_fsm_if.sv
// Control/status bundle of the up/down sequence counter; the counter is the slave.
// Optional build macro: SEQ_UPDOWN_SATURATE_EN (no effect on this interface).
interface seq_updown_fsm_if
   import seq_fsm_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             en;
   logic             down;
   logic             gray_mode;
   logic             load;
   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] code_o;
   logic [WIDTH-1:0] bin_o;
   logic             wrap_o;
   logic             term_o;

   modport master (
      output en, down, gray_mode, load, load_val,
      input  code_o, bin_o, wrap_o, term_o
   );

   modport slave (
      input  en, down, gray_mode, load, load_val,
      output code_o, bin_o, wrap_o, term_o
   );

endinterface

// File: rtl/seq_updown_fsm_step_logic.sv
// Combinational single-step calculation: next count, wrap event and terminal flag.
// Optional build macro: SEQ_UPDOWN_SATURATE_EN (hold at the limit instead of wrapping).
module seq_step_logic #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 2**WIDTH
) (
   input  logic [WIDTH-1:0] i_cnt,
   input  logic             i_down,
   output logic [WIDTH-1:0] o_next,
   output logic             o_wrap,
   output logic             o_term
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   always_comb begin
      // NOTE: every output gets a default first so no path through the block can infer a latch.
      o_next = i_cnt;
      o_wrap = 1'b0;
      o_term = i_down ? (i_cnt == '0) : (i_cnt == MAX_CNT);

      if (o_term) begin
`ifdef SEQ_UPDOWN_SATURATE_EN
         o_next = i_cnt;
`else
         o_next = i_down ? MAX_CNT : '0;
         o_wrap = 1'b1;
`endif
      end else begin
         o_next = i_down ? (i_cnt - WIDTH'(1)) : (i_cnt + WIDTH'(1));
      end
   end

endmodule

// File: rtl/seq_updown_fsm.sv
// Registered up/down sequence counter with run-time binary/Gray output encoding.
// Optional build macro: SEQ_UPDOWN_SATURATE_EN (saturating limits, see seq_step_logic).
module seq_updown_fsm
   import seq_fsm_pkg::*;
#(
   parameter int WIDTH   = DEFAULT_WIDTH,
   parameter int MODULUS = 2**WIDTH
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seq_updown_fsm_if.slave        bus
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MODULUS - 1);

   logic [WIDTH-1:0] r_cnt;
   logic [WIDTH-1:0] r_code;
   logic             r_wrap;

   enc_mode_t        w_mode;
   logic [WIDTH-1:0] w_load_dec;
   logic [WIDTH-1:0] w_step_cnt;
   logic             w_step_wrap;
   logic             w_step_term;
   logic [WIDTH-1:0] w_cnt_nxt;
   logic             w_wrap_nxt;
   logic [WIDTH-1:0] w_code_nxt;

   seq_step_logic #(
      .WIDTH   (WIDTH),
      .MODULUS (MODULUS)
   ) u_step (
      .i_cnt  (r_cnt),
      .i_down (bus.down),
      .o_next (w_step_cnt),
      .o_wrap (w_step_wrap),
      .o_term (w_step_term)
   );

   always_comb begin
      w_mode     = enc_mode_t'(bus.gray_mode);
      w_load_dec = bus.load_val;
      w_cnt_nxt  = r_cnt;
      w_wrap_nxt = 1'b0;

      if (w_mode == ENC_GRAY) begin
         w_load_dec = WIDTH'(gray2bin(MAX_WIDTH'(bus.load_val)));
      end

      if (bus.load) begin
         w_cnt_nxt = (w_load_dec > MAX_CNT) ? MAX_CNT : w_load_dec;
      end else if (bus.en) begin
         w_cnt_nxt  = w_step_cnt;
         w_wrap_nxt = w_step_wrap;
      end

      // code_o is registered from the next count so it lines up with bin_o.
      w_code_nxt = (w_mode == ENC_GRAY) ? WIDTH'(bin2gray(MAX_WIDTH'(w_cnt_nxt))) : w_cnt_nxt;
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so all of them update together at the edge.
      if (!rst_n) begin
         r_cnt  <= '0;
         r_code <= '0;
         r_wrap <= 1'b0;
      end else begin
         r_cnt  <= w_cnt_nxt;
         r_code <= w_code_nxt;
         r_wrap <= w_wrap_nxt;
      end
   end

   assign bus.bin_o  = r_cnt;
   assign bus.code_o = r_code;
   assign bus.wrap_o = r_wrap;
   assign bus.term_o = w_step_term;

endmodule

// File: tb/tb_seq_updown_fsm.sv
// Scoreboard bench for seq_updown_fsm: a MODULUS=8 and a MODULUS=6 instance share stimulus.
// Optional build macro: SEQ_UPDOWN_SATURATE_EN selects the saturating expectations.
module tb_seq_updown_fsm;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   seq_updown_fsm_if #(.WIDTH(3)) bus0 ();
   seq_updown_fsm_if #(.WIDTH(3)) bus1 ();

   seq_updown_fsm #(.WIDTH(3), .MODULUS(8)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   seq_updown_fsm #(.WIDTH(3), .MODULUS(6)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   typedef struct {
      int          dut;
      string       name;
      logic [2:0]  code;
      logic [2:0]  bin;
      logic        wrap;
      logic        term;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Apply one cycle of stimulus to both instances at the falling edge.
   task automatic cyc(input logic rst, input logic en, input logic down, input logic gm,
                      input logic load, input logic [2:0] lv);
      @(negedge clk);
      rst_n          = rst;
      bus0.en        = en;   bus1.en        = en;
      bus0.down      = down; bus1.down      = down;
      bus0.gray_mode = gm;   bus1.gray_mode = gm;
      bus0.load      = load; bus1.load      = load;
      bus0.load_val  = lv;   bus1.load_val  = lv;
   endtask

   task automatic exp0(input string name, input logic [2:0] code, input logic [2:0] bin,
                       input logic wrap, input logic term);
      exp_t e;
      e.dut = 0; e.name = name; e.code = code; e.bin = bin; e.wrap = wrap; e.term = term;
      exp_q.push_back(e);
   endtask

   task automatic exp1(input string name, input logic [2:0] code, input logic [2:0] bin,
                       input logic wrap, input logic term);
      exp_t e;
      e.dut = 1; e.name = name; e.code = code; e.bin = bin; e.wrap = wrap; e.term = term;
      exp_q.push_back(e);
   endtask

   // Monitor: every rising edge presents a new registered output; compare just after it.
   initial begin
      exp_t       e;
      logic [2:0] a_code, a_bin;
      logic       a_wrap, a_term;
      forever begin
         @(posedge clk);
         #1;
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.dut == 0) begin
               a_code = bus0.code_o; a_bin = bus0.bin_o; a_wrap = bus0.wrap_o; a_term = bus0.term_o;
            end else begin
               a_code = bus1.code_o; a_bin = bus1.bin_o; a_wrap = bus1.wrap_o; a_term = bus1.term_o;
            end
            check($sformatf("d%0d_%s_code", e.dut, e.name), 32'(a_code), 32'(e.code));
            check($sformatf("d%0d_%s_bin",  e.dut, e.name), 32'(a_bin),  32'(e.bin));
            check($sformatf("d%0d_%s_wrap", e.dut, e.name), 32'(a_wrap), 32'(e.wrap));
            check($sformatf("d%0d_%s_term", e.dut, e.name), 32'(a_term), 32'(e.term));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      logic [2:0] gtab [8];
      logic [2:0] b;
      gtab = '{3'b100, 3'b101, 3'b111, 3'b110, 3'b010, 3'b011, 3'b001, 3'b000};

      bus0.en = 0; bus0.down = 0; bus0.gray_mode = 0; bus0.load = 0; bus0.load_val = 0;
      bus1.en = 0; bus1.down = 0; bus1.gray_mode = 0; bus1.load = 0; bus1.load_val = 0;

      // Reset for two cycles, then hold.
      for (int i = 0; i < 2; i++) begin
         cyc(0, 0, 0, 0, 0, 0); exp0("rst", 0, 0, 0, 0); exp1("rst", 0, 0, 0, 0);
      end
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 0, 0, 0); exp0("hold", 0, 0, 0, 0);
      end

`ifndef SEQ_UPDOWN_SATURATE_EN
      // Binary count up through the 7->0 wrap.
      for (int i = 1; i <= 8; i++) begin
         b = 3'(i % 8);
         cyc(1, 1, 0, 0, 0, 0);
         exp0($sformatf("up%0d", i), b, b, i == 8, b == 3'd7);
      end

      // Gray count down from 0, wrapping to 7 on the first step.
      for (int i = 0; i < 8; i++) begin
         cyc(1, 1, 1, 1, 0, 0);
         exp0($sformatf("gdown%0d", i), gtab[i], 3'(7 - i), i == 0, i == 7);
      end

      // Direction change has no extra latency.
      cyc(1, 1, 0, 1, 0, 0); exp0("dir_up", 3'b001, 1, 0, 0);
      cyc(1, 1, 1, 1, 0, 0); exp0("dir_dn", 3'b000, 0, 0, 1);
`endif

      // gray_mode change while idle re-encodes code_o only.
      cyc(1, 0, 0, 0, 1, 3); exp0("ld3", 3'b011, 3, 0, 0);
      cyc(1, 0, 0, 1, 0, 0); exp0("gm_on", 3'b010, 3, 0, 0);
      cyc(1, 0, 0, 0, 0, 0); exp0("gm_off", 3'b011, 3, 0, 0);

      // Load beats en; Gray-encoded load decodes before storing.
      cyc(1, 1, 0, 0, 1, 5);      exp0("ld5_en", 3'b101, 5, 0, 0);
      cyc(1, 0, 0, 1, 1, 3'b110); exp0("ld_gray4", 3'b110, 4, 0, 0);
      cyc(1, 0, 0, 0, 1, 7);      exp0("ld7", 3'b111, 7, 0, 1);
      cyc(1, 1, 0, 0, 1, 7);      exp0("ld7_en", 3'b111, 7, 0, 1);
`ifndef SEQ_UPDOWN_SATURATE_EN
      cyc(1, 1, 0, 0, 0, 0);      exp0("wrap_after_ld", 0, 0, 1, 0);
      cyc(1, 1, 0, 0, 0, 0);      exp0("after_wrap", 1, 1, 0, 0);
`endif

      // MODULUS=6 clamping and wrap; dut0 sees the same Gray load unclamped.
      cyc(1, 0, 0, 0, 1, 7);      exp1("clamp_bin", 5, 5, 0, 1);
      cyc(1, 0, 0, 1, 1, 3'b100); exp1("clamp_gray", 3'b111, 5, 0, 1);
                                  exp0("ld_gray7", 3'b100, 7, 0, 1);
`ifndef SEQ_UPDOWN_SATURATE_EN
      cyc(1, 1, 0, 0, 0, 0);      exp1("m6_wrap_up", 0, 0, 1, 0);
      cyc(1, 1, 1, 0, 0, 0);      exp1("m6_wrap_dn", 5, 5, 1, 0);
`endif

      // Reset mid-run overrides a simultaneous load and en.
      cyc(1, 0, 0, 0, 1, 2); exp0("ld2", 2, 2, 0, 0);
      cyc(1, 1, 0, 0, 0, 0); exp0("to3", 3, 3, 0, 0);
      cyc(1, 1, 0, 0, 0, 0); exp0("to4", 4, 4, 0, 0);
      cyc(0, 1, 0, 0, 1, 5); exp0("rst_mid", 0, 0, 0, 0); exp1("rst_mid", 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0); exp0("post_rst", 0, 0, 0, 0);

`ifdef SEQ_UPDOWN_SATURATE_EN
      // Saturation at both limits with no wrap pulse.
      cyc(1, 0, 0, 0, 1, 6); exp0("sat_ld6", 6, 6, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc(1, 1, 0, 0, 0, 0); exp0($sformatf("sat_up%0d", i), 7, 7, 0, 1);
      end
      cyc(1, 1, 1, 0, 0, 0); exp0("sat_dn6", 6, 6, 0, 0);
      cyc(1, 0, 1, 0, 1, 1); exp0("sat_ld1", 1, 1, 0, 0);
      cyc(1, 1, 1, 0, 0, 0); exp0("sat_dn0", 0, 0, 0, 1);
      cyc(1, 1, 1, 0, 0, 0); exp0("sat_hold0", 0, 0, 0, 1);
`endif

      cyc(1, 0, 0, 0, 0, 0);
      @(posedge clk);
      #2;
      check("scoreboard_drain", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
